// File: rtl/learning_mode_controller.sv
// Learning-mode engine: walks a fixed 14-note phrase, waits for the matching
// debounced key, and plays that note's square-wave tone while it is held.
module learning_mode_controller #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TONE_SHIFT      = 0,
  parameter int SONG_LEN        = 14
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [6:0] key_in,
  output logic [3:0] note_out,
  output logic       speaker,
  output logic       error,
  output logic       done,
  output logic [7:0] miss_count
);

  // state      | meaning
  // S_IDLE     | learning mode not selected, outputs quiet
  // S_WAIT_KEY | showing ROM[index], waiting for a press
  // S_HOLD     | correct key held, tone playing
  // S_WRONG    | wrong/invalid key held, error raised
  // S_DONE     | phrase completed
  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_KEY,
    S_HOLD,
    S_WRONG,
    S_DONE
  } state_t;

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]      LAST_IDX = 4'(SONG_LEN - 1);

  function automatic logic [3:0] f_song(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd1, 4'd13: return 4'd1;
      4'd2, 4'd3, 4'd6:  return 4'd5;
      4'd4, 4'd5:        return 4'd6;
      4'd7, 4'd8:        return 4'd4;
      4'd9, 4'd10:       return 4'd3;
      4'd11, 4'd12:      return 4'd2;
      default:           return 4'd0;
    endcase
  endfunction

  function automatic logic [17:0] f_half(input logic [3:0] note);
    case (note)
      4'd1:    return 18'(191110 >> TONE_SHIFT);
      4'd2:    return 18'(170265 >> TONE_SHIFT);
      4'd3:    return 18'(151685 >> TONE_SHIFT);
      4'd4:    return 18'(143172 >> TONE_SHIFT);
      4'd5:    return 18'(127551 >> TONE_SHIFT);
      4'd6:    return 18'(113636 >> TONE_SHIFT);
      4'd7:    return 18'(101239 >> TONE_SHIFT);
      default: return 18'd1;
    endcase
  endfunction

  state_t          r_state, w_state_nxt;
  logic [3:0]      r_index, w_index_nxt;
  logic [7:0]      r_miss, w_miss_nxt;
  logic [3:0]      r_play, w_play_nxt;
  logic [3:0]      r_note;
  logic            r_error, r_done, r_speaker;
  logic [6:0]      r_cand, r_key_db;
  logic [DB_W-1:0] r_db_cnt;
  logic [17:0]     r_tone_cnt;
  logic            w_stable;
  logic [6:0]      w_key_db;
  logic [3:0]      w_pressed;
  logic            w_single;
  logic [17:0]     w_half_m1;
  logic            w_show_note;

  // The FSM acts on the debounced value on the same edge it is accepted.
  assign w_stable = (key_in == r_cand) && (r_db_cnt == DB_LAST);
  assign w_key_db = w_stable ? r_cand : r_key_db;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cand   <= 7'd0;
      r_db_cnt <= '0;
      r_key_db <= 7'd0;
    end else begin
      if (key_in != r_cand) begin
        r_cand   <= key_in;
        r_db_cnt <= '0;
      end else if (r_db_cnt != DB_LAST) begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
      r_key_db <= w_key_db;
    end
  end

  always_comb begin
    w_pressed = 4'd0;
    for (int i = 0; i < 7; i++) begin
      if (w_key_db[i]) w_pressed = 4'(i + 1);
    end
  end
  assign w_single = $onehot(w_key_db);

  always_comb begin
    w_state_nxt = r_state;
    w_index_nxt = r_index;
    w_miss_nxt  = r_miss;
    w_play_nxt  = r_play;
    if (!enable) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_WAIT_KEY;
          w_index_nxt = 4'd0;
          w_miss_nxt  = 8'd0;
        end
        S_WAIT_KEY: begin
          if (w_key_db != 7'd0) begin
            if (w_single && (w_pressed == f_song(r_index))) begin
              w_state_nxt = S_HOLD;
              w_play_nxt  = w_pressed;
            end else begin
              w_state_nxt = S_WRONG;
              if (r_miss != 8'hFF) w_miss_nxt = r_miss + 8'd1;
            end
          end
        end
        S_HOLD: begin
          if (w_key_db == 7'd0) begin
            if (r_index == LAST_IDX) begin
              w_state_nxt = S_DONE;
            end else begin
              w_state_nxt = S_WAIT_KEY;
              w_index_nxt = r_index + 4'd1;
            end
          end
        end
        S_WRONG: begin
          if (w_key_db == 7'd0) w_state_nxt = S_WAIT_KEY;
        end
        S_DONE:  w_state_nxt = S_DONE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign w_show_note = (w_state_nxt == S_WAIT_KEY) || (w_state_nxt == S_HOLD) ||
                       (w_state_nxt == S_WRONG);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_index <= 4'd0;
      r_miss  <= 8'd0;
      r_play  <= 4'd0;
      r_note  <= 4'd0;
      r_error <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_index <= w_index_nxt;
      r_miss  <= w_miss_nxt;
      r_play  <= w_play_nxt;
      r_note  <= w_show_note ? f_song(w_index_nxt) : 4'd0;
      r_error <= (w_state_nxt == S_WRONG);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  assign w_half_m1 = f_half(r_play) - 18'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tone_cnt <= 18'd0;
      r_speaker  <= 1'b0;
    end else if ((w_state_nxt == S_HOLD) && (r_state == S_HOLD)) begin
      if (r_tone_cnt == w_half_m1) begin
        r_tone_cnt <= 18'd0;
        r_speaker  <= ~r_speaker;
      end else begin
        r_tone_cnt <= r_tone_cnt + 18'd1;
      end
    end else begin
      r_tone_cnt <= 18'd0;
      r_speaker  <= 1'b0;
    end
  end

  assign note_out   = r_note;
  assign speaker    = r_speaker;
  assign error      = r_error;
  assign done       = r_done;
  assign miss_count = r_miss;

endmodule
